// File: rtl/ctrl_decode_stage_pkg.sv
// Shared opcode/function constants, memory-access encodings and control bundle
// types for the ID-stage control decoder.
package ctrl_decode_stage_pkg;

   localparam int MUL_LAT_DEF = 2;
   localparam int DIV_LAT_DEF = 33;
   localparam int CNT_W_DEF   = 6;

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_REGIMM  = 6'h01;
   localparam logic [5:0] OP_J       = 6'h02;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_BNE     = 6'h05;
   localparam logic [5:0] OP_BLEZ    = 6'h06;
   localparam logic [5:0] OP_BGTZ    = 6'h07;
   localparam logic [5:0] OP_ADDI    = 6'h08;
   localparam logic [5:0] OP_ADDIU   = 6'h09;
   localparam logic [5:0] OP_SLTI    = 6'h0A;
   localparam logic [5:0] OP_SLTIU   = 6'h0B;
   localparam logic [5:0] OP_ANDI    = 6'h0C;
   localparam logic [5:0] OP_ORI     = 6'h0D;
   localparam logic [5:0] OP_XORI    = 6'h0E;
   localparam logic [5:0] OP_LUI     = 6'h0F;
   localparam logic [5:0] OP_COP0    = 6'h10;
   localparam logic [5:0] OP_LB      = 6'h20;
   localparam logic [5:0] OP_LH      = 6'h21;
   localparam logic [5:0] OP_LW      = 6'h23;
   localparam logic [5:0] OP_LBU     = 6'h24;
   localparam logic [5:0] OP_LHU     = 6'h25;
   localparam logic [5:0] OP_SB      = 6'h28;
   localparam logic [5:0] OP_SH      = 6'h29;
   localparam logic [5:0] OP_SW      = 6'h2B;

   localparam logic [5:0] FUNC_SLL     = 6'h00;
   localparam logic [5:0] FUNC_SRL     = 6'h02;
   localparam logic [5:0] FUNC_SRA     = 6'h03;
   localparam logic [5:0] FUNC_SLLV    = 6'h04;
   localparam logic [5:0] FUNC_SRLV    = 6'h06;
   localparam logic [5:0] FUNC_SRAV    = 6'h07;
   localparam logic [5:0] FUNC_JR      = 6'h08;
   localparam logic [5:0] FUNC_JALR    = 6'h09;
   localparam logic [5:0] FUNC_SYSCALL = 6'h0C;
   localparam logic [5:0] FUNC_BREAK   = 6'h0D;
   localparam logic [5:0] FUNC_MFHI    = 6'h10;
   localparam logic [5:0] FUNC_MTHI    = 6'h11;
   localparam logic [5:0] FUNC_MFLO    = 6'h12;
   localparam logic [5:0] FUNC_MTLO    = 6'h13;
   localparam logic [5:0] FUNC_MULT    = 6'h18;
   localparam logic [5:0] FUNC_MULTU   = 6'h19;
   localparam logic [5:0] FUNC_DIV     = 6'h1A;
   localparam logic [5:0] FUNC_DIVU    = 6'h1B;
   localparam logic [5:0] FUNC_ADD     = 6'h20;
   localparam logic [5:0] FUNC_ADDU    = 6'h21;
   localparam logic [5:0] FUNC_SUB     = 6'h22;
   localparam logic [5:0] FUNC_SUBU    = 6'h23;
   localparam logic [5:0] FUNC_AND     = 6'h24;
   localparam logic [5:0] FUNC_OR      = 6'h25;
   localparam logic [5:0] FUNC_XOR     = 6'h26;
   localparam logic [5:0] FUNC_NOR     = 6'h27;
   localparam logic [5:0] FUNC_SLT     = 6'h2A;
   localparam logic [5:0] FUNC_SLTU    = 6'h2B;
   localparam logic [5:0] FUNC_ERET    = 6'h18;

   localparam logic [4:0] RT_BLTZ   = 5'h00;
   localparam logic [4:0] RT_BGEZ   = 5'h01;
   localparam logic [4:0] RT_BLTZAL = 5'h10;
   localparam logic [4:0] RT_BGEZAL = 5'h11;
   localparam logic [4:0] RS_CO     = 5'h10;

   typedef enum logic [2:0] {
      MT_BYTE_U = 3'b000,
      MT_HALF_U = 3'b001,
      MT_WORD   = 3'b010,
      MT_BYTE   = 3'b100,
      MT_HALF   = 3'b101,
      MT_NONE   = 3'b111
   } mem_type_e;

   typedef struct packed {
      logic      mem_read;
      logic      mem_write;
      logic      reg_write;
      logic      mem_to_reg;
      mem_type_e mem_type;
      logic      jump;
      logic      branch;
      logic      alu_src_a;
      logic      alu_src_b;
      logic      reg_dst;
      logic      imm_sel;
      logic      epc_sel;
      logic      hilo_we;
      logic      ri;
   } ctrl_t;

   typedef struct packed {
      logic any;
      logic mul;
      logic div;
      logic mt;
   } hilo_cls_t;

   localparam ctrl_t CTRL_RESET = '{mem_type: MT_NONE, default: 1'b0};

endpackage

// File: rtl/ctrl_decode_stage_if.sv
// ID-stage handshake bus: IF/ID instruction in, ID/EX control bundle out.
interface ctrl_decode_stage_if;
   import ctrl_decode_stage_pkg::*;

   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        out_mem_read;
   logic        out_mem_write;
   logic        out_reg_write;
   logic        out_mem_to_reg;
   logic [2:0]  out_mem_type;
   logic        out_jump;
   logic        out_branch;
   logic        out_alu_src_a;
   logic        out_alu_src_b;
   logic        out_reg_dst;
   logic        out_imm_sel;
   logic        out_epc_sel;
   logic        out_hilo_we;
   logic        out_ri;
   logic        hilo_busy;

   modport master (
      output in_valid, in_instr, in_pc, flush, out_ready,
      input  in_ready, out_valid, out_instr, out_pc, out_mem_read, out_mem_write,
             out_reg_write, out_mem_to_reg, out_mem_type, out_jump, out_branch,
             out_alu_src_a, out_alu_src_b, out_reg_dst, out_imm_sel, out_epc_sel,
             out_hilo_we, out_ri, hilo_busy
   );

   modport slave (
      input  in_valid, in_instr, in_pc, flush, out_ready,
      output in_ready, out_valid, out_instr, out_pc, out_mem_read, out_mem_write,
             out_reg_write, out_mem_to_reg, out_mem_type, out_jump, out_branch,
             out_alu_src_a, out_alu_src_b, out_reg_dst, out_imm_sel, out_epc_sel,
             out_hilo_we, out_ri, hilo_busy
   );

endinterface

// File: rtl/ctrl_decode_stage_comb.sv
// Pure combinational MIPS-I decode: instruction word to EX control bundle,
// reserved-instruction flag and HI/LO class flags.
module ctrl_decode_comb
   import ctrl_decode_stage_pkg::*;
(
   input  logic [31:0] instr,
   output ctrl_t       ctrl,
   output hilo_cls_t   hilo
);

   logic [5:0] op, fn;
   logic [4:0] rs, rt;
   logic       unused_bits;

   assign op          = instr[31:26];
   assign rs          = instr[25:21];
   assign rt          = instr[20:16];
   assign fn          = instr[5:0];
   assign unused_bits = ^instr[15:6];

   logic known, is_load, is_store, is_ialu, is_br, is_regimm, is_j, is_jal;
   logic is_jr, is_jalr, is_trap, is_shamt, is_eret, is_mf, is_mt, is_mul, is_div;
   mem_type_e mtype;

   always_comb begin
      known     = 1'b0;
      is_load   = 1'b0;
      is_store  = 1'b0;
      is_ialu   = 1'b0;
      is_br     = 1'b0;
      is_regimm = 1'b0;
      is_j      = 1'b0;
      is_jal    = 1'b0;
      is_jr     = 1'b0;
      is_jalr   = 1'b0;
      is_trap   = 1'b0;
      is_shamt  = 1'b0;
      is_eret   = 1'b0;
      is_mf     = 1'b0;
      is_mt     = 1'b0;
      is_mul    = 1'b0;
      is_div    = 1'b0;
      mtype     = MT_NONE;
      case (op)
         OP_SPECIAL: begin
            known = 1'b1;
            case (fn)
               FUNC_SLL, FUNC_SRL, FUNC_SRA:          is_shamt = 1'b1;
               FUNC_SLLV, FUNC_SRLV, FUNC_SRAV,
               FUNC_ADD, FUNC_ADDU, FUNC_SUB, FUNC_SUBU,
               FUNC_AND, FUNC_OR, FUNC_XOR, FUNC_NOR,
               FUNC_SLT, FUNC_SLTU:                   ;
               FUNC_JR:                               is_jr   = 1'b1;
               FUNC_JALR:                             is_jalr = 1'b1;
               FUNC_SYSCALL, FUNC_BREAK:              is_trap = 1'b1;
               FUNC_MFHI, FUNC_MFLO:                  is_mf   = 1'b1;
               FUNC_MTHI, FUNC_MTLO:                  is_mt   = 1'b1;
               FUNC_MULT, FUNC_MULTU:                 is_mul  = 1'b1;
               FUNC_DIV, FUNC_DIVU:                   is_div  = 1'b1;
               default:                               known   = 1'b0;
            endcase
         end
         OP_REGIMM: begin
            // Only the four MIPS-I REGIMM branches; other rt codes are reserved.
            if (rt == RT_BLTZ || rt == RT_BGEZ || rt == RT_BLTZAL || rt == RT_BGEZAL) begin
               known     = 1'b1;
               is_regimm = 1'b1;
            end
         end
         OP_J:   begin known = 1'b1; is_j   = 1'b1; end
         OP_JAL: begin known = 1'b1; is_jal = 1'b1; end
         OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin known = 1'b1; is_br = 1'b1; end
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
         OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin known = 1'b1; is_ialu = 1'b1; end
         OP_COP0: begin
            if (rs == RS_CO && fn == FUNC_ERET) begin
               known   = 1'b1;
               is_eret = 1'b1;
            end
         end
         OP_LB:  begin known = 1'b1; is_load  = 1'b1; mtype = MT_BYTE;   end
         OP_LBU: begin known = 1'b1; is_load  = 1'b1; mtype = MT_BYTE_U; end
         OP_LH:  begin known = 1'b1; is_load  = 1'b1; mtype = MT_HALF;   end
         OP_LHU: begin known = 1'b1; is_load  = 1'b1; mtype = MT_HALF_U; end
         OP_LW:  begin known = 1'b1; is_load  = 1'b1; mtype = MT_WORD;   end
         OP_SB:  begin known = 1'b1; is_store = 1'b1; mtype = MT_BYTE_U; end
         OP_SH:  begin known = 1'b1; is_store = 1'b1; mtype = MT_HALF_U; end
         OP_SW:  begin known = 1'b1; is_store = 1'b1; mtype = MT_WORD;   end
         default: ;
      endcase
   end

   always_comb begin
      ctrl            = CTRL_RESET;
      ctrl.mem_read   = is_load;
      ctrl.mem_write  = is_store;
      ctrl.reg_write  = known & ~(is_br | is_regimm | is_j | is_jr | is_trap | is_store);
      ctrl.mem_to_reg = is_load;
      ctrl.mem_type   = mtype;
      ctrl.jump       = is_j | is_jal | is_jr | is_jalr;
      ctrl.branch     = is_br | is_regimm;
      ctrl.alu_src_a  = is_shamt | is_jalr | is_regimm | is_eret;
      ctrl.alu_src_b  = is_ialu | is_load | is_store | is_jal;
      ctrl.reg_dst    = ~(is_ialu | is_load | is_store | is_jal) | is_jalr | is_jal | is_regimm;
      ctrl.imm_sel    = is_regimm | is_jal | is_jalr;
      ctrl.epc_sel    = is_eret;
      ctrl.hilo_we    = is_mul | is_div | is_mt;
      ctrl.ri         = ~known;
   end

   assign hilo = '{any: is_mf | is_mt | is_mul | is_div, mul: is_mul, div: is_div, mt: is_mt};

endmodule

// File: rtl/ctrl_decode_stage.sv
// ID/EX control slot with valid/ready handshake, flush, and a HI/LO busy
// counter that holds HI/LO readers and writers in ID until results settle.
module ctrl_decode_stage
   import ctrl_decode_stage_pkg::*;
#(
   parameter int MUL_LAT = MUL_LAT_DEF,
   parameter int DIV_LAT = DIV_LAT_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input logic           clk,
   input logic           rst,
   ctrl_decode_stage_if.slave bus
);

   if ((2 ** CNT_W) <= MUL_LAT || (2 ** CNT_W) <= DIV_LAT) begin : g_cnt_w_check
      $error("CNT_W too narrow for MUL_LAT/DIV_LAT");
   end

   ctrl_t     dec_ctrl;
   hilo_cls_t dec_hilo;

   ctrl_decode_comb u_dec (
      .instr (bus.in_instr),
      .ctrl  (dec_ctrl),
      .hilo  (dec_hilo)
   );

   logic             slot_valid, slot_mul, slot_div, slot_mt;
   logic [31:0]      slot_instr, slot_pc;
   ctrl_t            slot_ctrl;
   logic [CNT_W-1:0] cnt;
   logic             out_fire, slot_free, hilo_pend, hazard, in_ready, take;

   assign out_fire  = slot_valid & bus.out_ready & ~bus.flush;
   assign slot_free = ~slot_valid | out_fire;
   // The slot itself counts as pending: its HI/LO op has not reached EX yet.
   assign hilo_pend = (cnt != '0) | (slot_valid & slot_ctrl.hilo_we);
   assign hazard    = hilo_pend & dec_hilo.any;
   assign in_ready  = slot_free & ~hazard & ~bus.flush;
   assign take      = bus.in_valid & in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         slot_valid <= 1'b0;
         slot_instr <= '0;
         slot_pc    <= '0;
         slot_ctrl  <= CTRL_RESET;
         slot_mul   <= 1'b0;
         slot_div   <= 1'b0;
         slot_mt    <= 1'b0;
         cnt        <= '0;
      end else begin
         if (take) begin
            slot_valid <= 1'b1;
            slot_instr <= bus.in_instr;
            slot_pc    <= bus.in_pc;
            slot_ctrl  <= dec_ctrl;
            slot_mul   <= dec_hilo.mul;
            slot_div   <= dec_hilo.div;
            slot_mt    <= dec_hilo.mt;
         end else if (out_fire | bus.flush) begin
            slot_valid <= 1'b0;
            slot_instr <= '0;
            slot_pc    <= '0;
            slot_ctrl  <= CTRL_RESET;
            slot_mul   <= 1'b0;
            slot_div   <= 1'b0;
            slot_mt    <= 1'b0;
         end
         // Flush suppresses out_fire, so a flushed op never loads the counter,
         // while a count already in flight keeps draining.
         if (out_fire & slot_mul)      cnt <= CNT_W'(MUL_LAT);
         else if (out_fire & slot_div) cnt <= CNT_W'(DIV_LAT);
         else if (out_fire & slot_mt)  cnt <= '0;
         else if (cnt != '0)           cnt <= cnt - CNT_W'(1);
      end
   end

   assign bus.in_ready       = in_ready;
   assign bus.out_valid      = slot_valid;
   assign bus.out_instr      = slot_instr;
   assign bus.out_pc         = slot_pc;
   assign bus.out_mem_read   = slot_ctrl.mem_read;
   assign bus.out_mem_write  = slot_ctrl.mem_write;
   assign bus.out_reg_write  = slot_ctrl.reg_write;
   assign bus.out_mem_to_reg = slot_ctrl.mem_to_reg;
   assign bus.out_mem_type   = slot_ctrl.mem_type;
   assign bus.out_jump       = slot_ctrl.jump;
   assign bus.out_branch     = slot_ctrl.branch;
   assign bus.out_alu_src_a  = slot_ctrl.alu_src_a;
   assign bus.out_alu_src_b  = slot_ctrl.alu_src_b;
   assign bus.out_reg_dst    = slot_ctrl.reg_dst;
   assign bus.out_imm_sel    = slot_ctrl.imm_sel;
   assign bus.out_epc_sel    = slot_ctrl.epc_sel;
   assign bus.out_hilo_we    = slot_ctrl.hilo_we;
   assign bus.out_ri         = slot_ctrl.ri;
   assign bus.hilo_busy      = hilo_pend;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Directed + randomized bench for ctrl_decode_stage against a cycle-count
// reference model of the decode rules and HI/LO busy window.
module tb_ctrl_decode_stage;

   localparam int MUL_LAT = 2;
   localparam int DIV_LAT = 33;
   localparam logic [15:0] RST_CTRL = {4'b0000, 3'b111, 9'b0};

   localparam logic [31:0] ADDU = 32'h00851021;
   localparam logic [31:0] LW   = 32'h8C880004;
   localparam logic [31:0] DIV  = 32'h0085001A;
   localparam logic [31:0] MULT = 32'h00850018;
   localparam logic [31:0] MFHI = 32'h00001010;
   localparam logic [31:0] MFLO = 32'h00001812;
   localparam logic [31:0] RSVD = 32'hFC000123;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ctrl_decode_stage_if bus();

   ctrl_decode_stage #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(6)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          n_chk = 0, n_err = 0;
   int          cyc = 0, ready_cyc = 0;
   bit          m_valid = 1'b0;
   logic [31:0] m_instr = '0, m_pc = '0;
   bit          last_rdy;
   int          stalls;

   logic [5:0] hot_fns [12] = '{6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19,
                                6'h1A, 6'h1B, 6'h21, 6'h00, 6'h09, 6'h08};
   logic [5:0] hot_ops [16] = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h07, 6'h08, 6'h0F, 6'h10,
                                6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};

   logic [15:0] act_ctrl;
   assign act_ctrl = {bus.out_mem_read, bus.out_mem_write, bus.out_reg_write, bus.out_mem_to_reg,
                      bus.out_mem_type, bus.out_jump, bus.out_branch, bus.out_alu_src_a,
                      bus.out_alu_src_b, bus.out_reg_dst, bus.out_imm_sel, bus.out_epc_sel,
                      bus.out_hilo_we, bus.out_ri};

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Control bundle straight from the decode rules, packed in act_ctrl order.
   function automatic logic [15:0] exp_ctrl(input logic [31:0] i);
      logic [5:0] op = i[31:26];
      logic [5:0] fn = i[5:0];
      logic [4:0] rs = i[25:21];
      logic [4:0] rt = i[20:16];
      bit r      = (op == 6'h00);
      bit load   = op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
      bit store  = op inside {6'h28, 6'h29, 6'h2B};
      bit ialu   = op inside {[6'h08:6'h0F]};
      bit br     = op inside {[6'h04:6'h07]};
      bit regimm = (op == 6'h01) && (rt inside {5'h00, 5'h01, 5'h10, 5'h11});
      bit j      = (op == 6'h02);
      bit jal    = (op == 6'h03);
      bit jr     = r && fn == 6'h08;
      bit jalr   = r && fn == 6'h09;
      bit trap   = r && fn inside {6'h0C, 6'h0D};
      bit shift  = r && fn inside {6'h00, 6'h02, 6'h03};
      bit eret   = (op == 6'h10) && rs == 5'h10 && fn == 6'h18;
      bit hwe    = r && fn inside {6'h11, 6'h13, [6'h18:6'h1B]};
      bit rok    = r && fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0C,
                                   6'h0D, [6'h10:6'h13], [6'h18:6'h1B], [6'h20:6'h27], 6'h2A, 6'h2B};
      bit ok     = rok || regimm || j || jal || br || ialu || load || store || eret;
      bit srcb   = ialu || load || store || jal;
      logic [2:0] mt;
      case (op)
         6'h20:        mt = 3'b100;
         6'h24, 6'h28: mt = 3'b000;
         6'h21:        mt = 3'b101;
         6'h25, 6'h29: mt = 3'b001;
         6'h23, 6'h2B: mt = 3'b010;
         default:      mt = 3'b111;
      endcase
      return {load, store, ok && !(br || regimm || j || jr || trap || store), load, mt,
              j || jal || jr || jalr, br || regimm, shift || jalr || regimm || eret, srcb,
              !srcb || jalr || jal || regimm, regimm || jal || jalr, eret, hwe, !ok};
   endfunction

   function automatic bit hilo_any(input logic [31:0] i);
      return i[31:26] == 6'h00 && i[5:0] inside {[6'h10:6'h13], [6'h18:6'h1B]};
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] w = $urandom;
      int k = $urandom_range(0, 9);
      case (k)
         0: ;
         1, 2, 3, 4: begin w[31:26] = 6'h00; w[5:0] = hot_fns[$urandom_range(0, 11)]; end
         5: w[31:26] = 6'h00;
         6: w = 32'h42000018;
         7: begin w[31:26] = 6'h01; w[20:16] = {w[20], 3'b000, w[16]}; end
         default: w[31:26] = hot_ops[$urandom_range(0, 15)];
      endcase
      return w;
   endfunction

   // One clock: drive at negedge, check handshake, advance model at posedge,
   // then check the registered slot.
   task automatic step(input bit v, input logic [31:0] ins, input bit fl, input bit ordy, input bit r);
      bit pend, fire, rdy;
      logic [31:0] pc;
      @(negedge clk);
      pc = $urandom;
      rst = r; bus.in_valid = v; bus.in_instr = ins; bus.in_pc = pc;
      bus.flush = fl; bus.out_ready = ordy;
      #1;
      pend = (cyc < ready_cyc) || (m_valid && exp_ctrl(m_instr) & 16'h0002);
      fire = m_valid && ordy && !fl;
      rdy  = (!m_valid || fire) && !(pend && hilo_any(ins)) && !fl;
      last_rdy = bus.in_ready;
      if (!r) begin
         chk("in_ready", bus.in_ready, rdy);
         chk("hilo_busy", bus.hilo_busy, pend);
      end
      @(posedge clk);
      cyc++;
      if (r) begin
         m_valid = 1'b0; ready_cyc = cyc;
      end else begin
         if (fire && m_instr[31:26] == 6'h00) begin
            if (m_instr[5:0] inside {6'h18, 6'h19})      ready_cyc = cyc + MUL_LAT;
            else if (m_instr[5:0] inside {6'h1A, 6'h1B}) ready_cyc = cyc + DIV_LAT;
            else if (m_instr[5:0] inside {6'h11, 6'h13}) ready_cyc = cyc;
         end
         if (v && rdy) begin
            m_valid = 1'b1; m_instr = ins; m_pc = pc;
         end else if (fire || fl) begin
            m_valid = 1'b0;
         end
      end
      if (!m_valid) begin m_instr = '0; m_pc = '0; end
      #1;
      chk("out_valid", bus.out_valid, m_valid);
      chk("out_instr", bus.out_instr, m_instr);
      chk("out_pc", bus.out_pc, m_pc);
      chk("ctrl", act_ctrl, m_valid ? exp_ctrl(m_instr) : RST_CTRL);
   endtask

   initial begin
      bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0;
      bus.flush = 1'b0; bus.out_ready = 1'b0;

      step(0, '0, 0, 0, 1);
      step(0, '0, 0, 0, 1);
      chk("rst_mem_type", bus.out_mem_type, 3'b111);
      chk("rst_busy", bus.hilo_busy, 1'b0);

      // Back-to-back ADDU then LW.
      step(1, ADDU, 0, 1, 0);
      step(1, LW, 0, 1, 0);
      chk("b2b_valid", bus.out_valid, 1'b1);
      chk("lw_bits", {bus.out_mem_read, bus.out_mem_to_reg, bus.out_alu_src_b, bus.out_reg_write}, 4'hF);
      chk("lw_mem_type", bus.out_mem_type, 3'b010);
      step(0, '0, 0, 1, 0);

      // DIV fires, MFHI held off for the full divide window.
      step(1, DIV, 0, 1, 0);
      step(1, MFHI, 0, 1, 0);
      stalls = 0;
      for (int k = 0; k < 100; k++) begin
         step(1, MFHI, 0, 1, 0);
         if (last_rdy) break;
         stalls++;
      end
      chk("div_stall", stalls, DIV_LAT);
      step(0, '0, 0, 1, 0);

      // MULT parked in slot blocks MFLO, then MUL_LAT window after it fires.
      step(1, MULT, 0, 1, 0);
      repeat (3) step(1, MFLO, 0, 0, 0);
      chk("mult_park_rdy", last_rdy, 1'b0);
      chk("mult_park_busy", bus.hilo_busy, 1'b1);
      step(1, MFLO, 0, 1, 0);
      stalls = 0;
      for (int k = 0; k < 20; k++) begin
         step(1, MFLO, 0, 1, 0);
         if (last_rdy) break;
         stalls++;
      end
      chk("mul_stall", stalls, MUL_LAT);
      step(0, '0, 0, 1, 0);

      // Flushing a DIV must not start the counter.
      step(1, DIV, 0, 1, 0);
      step(0, '0, 1, 1, 0);
      chk("flush_valid", bus.out_valid, 1'b0);
      chk("flush_busy", bus.hilo_busy, 1'b0);
      step(1, MFHI, 0, 1, 0);
      chk("flush_mfhi_rdy", last_rdy, 1'b1);
      step(0, '0, 0, 1, 0);

      // Reserved opcode.
      step(1, RSVD, 0, 0, 0);
      chk("ri_flag", bus.out_ri, 1'b1);
      chk("ri_kill", {bus.out_reg_write, bus.out_mem_write, bus.out_mem_read, bus.out_hilo_we}, 4'h0);
      chk("ri_valid", bus.out_valid, 1'b1);
      step(0, '0, 0, 1, 0);

      // Reset with the divide counter at 20.
      step(1, DIV, 0, 1, 0);
      step(0, '0, 0, 1, 0);
      repeat (13) step(0, '0, 0, 1, 0);
      chk("cnt20_busy", bus.hilo_busy, 1'b1);
      step(0, '0, 0, 0, 1);
      chk("midrst_valid", bus.out_valid, 1'b0);
      chk("midrst_mem_type", bus.out_mem_type, 3'b111);
      chk("midrst_busy", bus.hilo_busy, 1'b0);
      step(1, MFHI, 0, 1, 0);
      chk("midrst_mfhi_rdy", last_rdy, 1'b1);

      for (int n = 0; n < 1500; n++)
         step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 15) == 0,
              $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/ctrl_decode_stage.md
Name: ctrl_decode_stage

Overview:
Registered ID-stage control decoder with a valid/ready handshake. It decodes a MIPS-I instruction word into the EX control bundle and holds that bundle in an ID/EX slot, with stall, flush and a HI/LO hazard scoreboard.
Multi-cycle MULT/DIV are tracked by a parametrised busy counter. Later HI/LO readers and writers are held in ID until the counter drains.
Adds reserved-instruction detection.

Parameters:
MUL_LAT, 2, cycles HI/LO stays busy after a MULT/MULTU issues to EX
DIV_LAT, 33, cycles HI/LO stays busy after a DIV/DIVU issues to EX
CNT_W, 6, busy-counter width; must satisfy 2^CNT_W > max(MUL_LAT, DIV_LAT)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  instruction word valid from IF/ID
in_ready  out  1  ID accepts instruction this cycle
in_instr  in  32  instruction word
in_pc  in  32  instruction PC
flush  in  1  discard the ID/EX slot (wrong path or exception)
out_valid  out  1  ID/EX slot holds a valid bundle
out_ready  in  1  EX accepts the bundle
out_instr, out_pc  out  32 each  registered passthrough
out_mem_read, out_mem_write, out_reg_write, out_mem_to_reg  out  1 each  memory and writeback controls
out_mem_type  out  3  100 LB, 000 LBU/SB, 101 LH, 001 LHU/SH, 010 LW/SW, 111 none
out_jump, out_branch, out_alu_src_a, out_alu_src_b, out_reg_dst, out_imm_sel, out_epc_sel, out_hilo_we  out  1 each  EX controls
out_ri  out  1  reserved instruction
hilo_busy  out  1  HI/LO result pending

Behaviour:
- Reset: out_valid=0, all out_* = 0 except out_mem_type=111; counter=0; hilo_busy=0.
- Decode is combinational on in_instr; all out_* are registered with 1-cycle latency from the in handshake.
- Decode rules:
  - out_reg_write=0 for branches, J, JR, BREAK, SYSCALL, stores.
  - out_mem_to_reg=1 for loads only.
  - out_alu_src_b=1 for I-type ALU ops, loads, stores and JAL.
  - out_reg_dst=~out_alu_src_b, forced to 1 for JALR, JAL and REGIMM.
  - out_imm_sel=1 for REGIMM, JAL and JALR.
  - out_alu_src_a=1 for SLL/SRL/SRA, JALR, REGIMM and ERET.
  - out_epc_sel=1 for ERET.
  - out_hilo_we=1 for MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- RI: any opcode/func outside the supported MIPS-I subset sets out_ri=1 and forces reg_write, mem_write, mem_read and hilo_we to 0.
- Handshake:
  - out_fire = out_valid & out_ready & ~flush.
  - slot_free = ~out_valid | out_fire.
  - in_ready = slot_free & ~hazard & ~flush.
  - The slot loads on in_valid & in_ready. Otherwise it clears on out_fire or flush, or holds.
- Hazard:
  - hilo_pend = (counter != 0) | (out_valid & out_hilo_we).
  - hazard = hilo_pend & the incoming instruction is one of MFHI, MFLO, MTHI, MTLO, MULT, MULTU, DIV, DIVU.
- Counter:
  - On out_fire of MULT/MULTU it loads MUL_LAT; on DIV/DIVU it loads DIV_LAT.
  - MTHI/MTLO load 0.
  - Otherwise it decrements to 0 and saturates there.
  - hilo_busy = hilo_pend.
- Flush has priority: the slot is cleared, no counter load, no capture that cycle. A counter already running is not cancelled, because that op already left ID.
- Simultaneous out_fire and capture: the slot is replaced in the same cycle (full throughput, no bubble).
- rst mid-count: the counter returns to 0 immediately.

Decomposition:
- Shared package: OP_*/FUNC_* opcode constants, MemType encodings, MUL_LAT/DIV_LAT defaults.
- Sub-module ctrl_decode_comb: pure combinational decode (instr to control bundle plus ri plus hilo-class flags).
- This block holds only the slot register, handshake and counter.

Test Plan:
- ADDU then LW, with out_ready=1 throughout → back-to-back out_valid. LW bundle: mem_read=1, mem_to_reg=1, mem_type=010, alu_src_b=1, reg_write=1.
- DIV issued (out_fire), followed by MFHI with in_valid held → in_ready=0 for exactly 33 cycles after the DIV fire. MFHI captured on the cycle the counter hits 0.
- MULT sitting in the slot with out_ready=0, MFLO presented → in_ready=0 and hilo_busy=1. After out_ready=1, the counter loads 2 and MFLO is accepted 2 cycles later.
- DIV in the slot, flush=1 with out_ready=1 the same cycle → out_valid=0 next cycle, counter remains 0, hilo_busy=0.
- Opcode 6'h3F presented → out_ri=1, reg_write=0, mem_write=0, hilo_we=0, out_valid=1.
- rst asserted at counter=20 → next cycle counter=0, out_valid=0, mem_type=111.
